array_multiplier_2x2: RTL and testbench
=======================================

ARRAY_MULTIPLIER_2X2 -- requirements
Module: array_multiplier_2x2

Interface
REQ-001 The block SHALL have no parameters; operand width 2 and product width 4 are fixed.
REQ-002 The block SHALL have port `clk`, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port `A`, input, 2 bits: unsigned multiplicand.
REQ-005 The block SHALL have port `B`, input, 2 bits: unsigned multiplier.
REQ-006 The block SHALL have port `valid_in`, input, 1 bit: A/B carry a new operand pair this cycle.
REQ-007 The block SHALL have port `P`, output, 4 bits: registered unsigned product A*B.
REQ-008 The block SHALL have port `valid_out`, output, 1 bit: P holds the product of the pair accepted on the previous edge.

Function
REQ-009 The block SHALL form partial products: pp00=A[0]&B[0], pp01=A[0]&B[1], pp10=A[1]&B[0], pp11=A[1]&B[1].
REQ-010 The block SHALL compute the product with a half-adder array: P[0]=pp00; HA1(pp10,pp01) gives sum P[1] and carry c1; HA2(pp11,c1) gives sum P[2] and carry P[3].
REQ-011 The computed product SHALL equal the unsigned product A*B for all 16 input pairs, with range 0..9 and no overflow possible.
REQ-012 On a rising clk edge with valid_in=1, the block SHALL load P with the array result of the current A and B, giving 1-cycle latency.
REQ-013 On a rising clk edge with valid_in=0, the block SHALL hold P at its previous value.
REQ-014 valid_out SHALL be valid_in registered on each rising edge: high for exactly one cycle per accepted pair, and back-to-back when valid_in stays high.
REQ-015 The block SHALL support a new operand pair every cycle, with no backpressure and no stall.
REQ-016 P and valid_out SHALL be driven only from flops, with no combinational path from inputs to outputs.
REQ-017 A and B values SHALL be ignored while valid_in=0, including X values.

Reset
REQ-018 While rst=1, the block SHALL hold P=4'b0000 and valid_out=0 immediately, independent of clk.
REQ-019 Reset asserted mid-stream SHALL discard any in-flight product; after deassertion, the first valid_in=1 edge SHALL produce the normal 1-cycle result.
REQ-020 With rst=1 and valid_in=1 simultaneously, reset SHALL win and no product is captured.

Structure
REQ-021 Width constants (operand width 2, product width 4) SHALL live in the shared package array_mult_pkg; no typedefs are needed.
REQ-022 The block SHALL contain one sub-module, half_adder (inputs a and b; outputs sum=a^b and carry=a&b), instantiated twice.
REQ-023 The partial-product AND gates SHALL be in the top level, and the output register SHALL be a single always block with asynchronous rst.

Verification
REQ-024 The bench SHALL apply A=00, B=00, valid_in=1, then 1 edge, and require P=0000 and valid_out=1.
REQ-025 The bench SHALL apply A=01/B=01, A=10/B=10 and A=11/B=11 on consecutive valid edges, and require P=0001, 0100 and 1001 on consecutive cycles.
REQ-026 The bench SHALL sweep all 16 A/B pairs with valid_in=1 every cycle, and require each P to equal A*B one cycle later with valid_out continuously 1.
REQ-027 The bench SHALL capture A=11/B=10 (P=0110), then drop valid_in with A/B changed, and require P to stay 0110 and valid_out=0.
REQ-028 The bench SHALL assert rst asynchronously mid-cycle while P=1001, and require P=0000 and valid_out=0 before the next edge; after release with A=10/B=11 valid, require P=0110.

Source files
------------

// File: rtl/array_mult_pkg.sv
// Shared width constants for the 2x2 array multiplier.
// Operand and product widths are fixed.
package array_mult_pkg;
  localparam int OP_W   = 2;
  localparam int PROD_W = 4;
endpackage

// File: rtl/array_multiplier_2x2_half_adder.sv
// Single-bit half adder used as a cell of the multiplier array.
// sum = a ^ b, carry = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/array_multiplier_2x2.sv
// 2x2 unsigned array multiplier with a registered product.
// One pair accepted per cycle; 1-cycle latency.
module array_multiplier_2x2
  import array_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  input  logic              valid_in,
  output logic [PROD_W-1:0] P,
  output logic              valid_out
);

  logic w_pp00;
  logic w_pp01;
  logic w_pp10;
  logic w_pp11;
  logic w_s1;
  logic w_c1;
  logic w_s2;
  logic w_c2;
  logic [PROD_W-1:0] w_prod;

  logic [PROD_W-1:0] r_p;
  logic              r_valid;

  assign w_pp00 = A[0] & B[0];
  assign w_pp01 = A[0] & B[1];
  assign w_pp10 = A[1] & B[0];
  assign w_pp11 = A[1] & B[1];

  half_adder u_ha1 (
    .a     (w_pp10),
    .b     (w_pp01),
    .sum   (w_s1),
    .carry (w_c1)
  );

  half_adder u_ha2 (
    .a     (w_pp11),
    .b     (w_c1),
    .sum   (w_s2),
    .carry (w_c2)
  );

  assign w_prod = {w_c2, w_s2, w_s1, w_pp00};

  // Capture the product on accepted pairs; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_p <= w_prod;
      end
    end
  end

  assign P         = r_p;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_array_multiplier_2x2.sv
// Directed self-checking bench for array_multiplier_2x2.
// Inputs change 1ns after a rising edge; outputs checked there.
module tb_array_multiplier_2x2;

  logic       clk;
  logic       rst;
  logic [1:0] A;
  logic [1:0] B;
  logic       valid_in;
  logic [3:0] P;
  logic       valid_out;

  int errors;
  int checks;

  logic [3:0] exp_tab [16];

  array_multiplier_2x2 dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .valid_in  (valid_in),
    .P         (P),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    A        = 2'b00;
    B        = 2'b00;
    #3;
    checks++;
    if (P !== 4'b0000) begin
      errors++;
      $display("FAIL reset_p got=%b exp=0000", P);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_v got=%b exp=0", valid_out);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zero();
    A        = 2'b00;
    B        = 2'b00;
    valid_in = 1'b1;
    tick();
    checks++;
    if (P !== 4'b0000) begin
      errors++;
      $display("FAIL zero_p got=%b exp=0000", P);
    end
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL zero_v got=%b exp=1", valid_out);
    end
  endtask

  task automatic test_diag();
    logic [1:0] ops [3];
    logic [3:0] exp [3];
    ops = '{2'b01, 2'b10, 2'b11};
    exp = '{4'b0001, 4'b0100, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      A        = ops[i];
      B        = ops[i];
      valid_in = 1'b1;
      tick();
      checks++;
      if (P !== exp[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL diag%0d got=%b/%b exp=%b/1",
                 i, P, valid_out, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin
      idx      = 4'(i);
      A        = idx[3:2];
      B        = idx[1:0];
      valid_in = 1'b1;
      tick();
      checks++;
      if (P !== exp_tab[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL sweep A=%0d B=%0d got=%b/%b exp=%b/1",
                 idx[3:2], idx[1:0], P, valid_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold();
    A        = 2'b11;
    B        = 2'b10;
    valid_in = 1'b1;
    tick();
    checks++;
    if (P !== 4'b0110) begin
      errors++;
      $display("FAIL hold_cap got=%b exp=0110", P);
    end
    valid_in = 1'b0;
    A        = 2'b01;
    B        = 2'b01;
    tick();
    checks++;
    if (P !== 4'b0110 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hold1 got=%b/%b exp=0110/0",
               P, valid_out);
    end
    A = 2'bxx;
    B = 2'bxx;
    tick();
    checks++;
    if (P !== 4'b0110 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_x got=%b/%b exp=0110/0",
               P, valid_out);
    end
  endtask

  task automatic test_async_reset();
    A        = 2'b11;
    B        = 2'b11;
    valid_in = 1'b1;
    tick();
    checks++;
    if (P !== 4'b1001 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got=%b/%b exp=1001/1",
               P, valid_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (P !== 4'b0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL ar_async got=%b/%b exp=0000/0",
               P, valid_out);
    end
    tick();
    checks++;
    if (P !== 4'b0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL ar_win got=%b/%b exp=0000/0",
               P, valid_out);
    end
    rst      = 1'b0;
    A        = 2'b10;
    B        = 2'b11;
    valid_in = 1'b1;
    tick();
    checks++;
    if (P !== 4'b0110 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL ar_post got=%b/%b exp=0110/1",
               P, valid_out);
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL ar_drop got=%b exp=0", valid_out);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_tab = '{4'd0, 4'd0, 4'd0, 4'd0,
                4'd0, 4'd1, 4'd2, 4'd3,
                4'd0, 4'd2, 4'd4, 4'd6,
                4'd0, 4'd3, 4'd6, 4'd9};
    test_reset();
    test_zero();
    test_diag();
    test_back_to_back();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
